// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the single vga_adapter pixel-write port among
// several draw engines; grants are held for a whole burst with a watchdog bound.

module vga_plot_lane #(
  parameter int X_W = 9,
  parameter int Y_W = 9,
  parameter int C_W = 3
) (
  input  logic           i_gnt,
  input  logic           i_plot,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic [C_W-1:0] i_c,
  output logic           o_hit,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [C_W-1:0] o_c
);
  // Masked lane data; the one-hot grant lets the top OR the lanes together.
  assign o_hit = i_gnt & i_plot;
  assign o_x   = i_x & {X_W{o_hit}};
  assign o_y   = i_y & {Y_W{o_hit}};
  assign o_c   = i_c & {C_W{o_hit}};
endmodule

module vga_plot_arbiter #(
  parameter int N_REQ     = 4,
  parameter int X_W       = 9,
  parameter int Y_W       = 9,
  parameter int C_W       = 3,
  parameter int MAX_BURST = 4096
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     plot_in,
  input  logic [N_REQ*X_W-1:0] x_in,
  input  logic [N_REQ*Y_W-1:0] y_in,
  input  logic [N_REQ*C_W-1:0] colour_in,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [C_W-1:0]       colour,
  output logic                 plot
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_rr;
  logic [CW-1:0]    r_cnt;
  logic             r_plot;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [C_W-1:0]   r_c;

  logic [N_REQ-1:0]          w_hit;
  logic [N_REQ-1:0][X_W-1:0] w_lx;
  logic [N_REQ-1:0][Y_W-1:0] w_ly;
  logic [N_REQ-1:0][C_W-1:0] w_lc;
  logic [X_W-1:0]            w_x;
  logic [Y_W-1:0]            w_y;
  logic [C_W-1:0]            w_c;
  logic                      w_found;
  logic [IW-1:0]             w_pick;
  logic                      w_rel;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      vga_plot_lane #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) u_lane (
        .i_gnt (r_gnt[gi]),
        .i_plot(plot_in[gi]),
        .i_x   (x_in[gi*X_W +: X_W]),
        .i_y   (y_in[gi*Y_W +: Y_W]),
        .i_c   (colour_in[gi*C_W +: C_W]),
        .o_hit (w_hit[gi]),
        .o_x   (w_lx[gi]),
        .o_y   (w_ly[gi]),
        .o_c   (w_lc[gi])
      );
    end
  endgenerate

  always_comb begin
    w_x = '0;
    w_y = '0;
    w_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_x = w_x | w_lx[i];
      w_y = w_y | w_ly[i];
      w_c = w_c | w_lc[i];
    end
  end

  // Scan from the farthest offset down so the nearest requester to r_rr wins.
  always_comb begin
    int s;
    w_found = 1'b0;
    w_pick  = '0;
    s       = 0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      s = int'(r_rr) + o;
      if (s >= N_REQ) s = s - N_REQ;
      if (req[s]) begin
        w_found = 1'b1;
        w_pick  = IW'(s);
      end
    end
  end

  assign w_rel = !req[r_idx] || (r_cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_busy  <= 1'b1;
            r_idx   <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (w_rel) begin
            r_state <= S_GAP;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_rr    <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel data holds between strobes so vga_adapter always sees the last pixel.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_plot <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
    end else begin
      r_plot <= |w_hit;
      if (|w_hit) begin
        r_x <= w_x;
        r_y <= w_y;
        r_c <= w_c;
      end
    end
  end

  assign gnt    = r_gnt;
  assign busy   = r_busy;
  assign plot   = r_plot;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_c;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: per-cycle vector table plus reset and
// watchdog sequences on a second instance built with a short burst limit.

module tb_vga_plot_arbiter;
  localparam int N = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic [N-1:0]       req, plot_in;
  logic [N-1:0][8:0]  xs;
  logic [N*9-1:0]     x_in, y_in;
  logic [N*3-1:0]     colour_in;

  logic [N-1:0] gnt_a, gnt_w;
  logic         busy_a, busy_w, plot_a, plot_w;
  logic [8:0]   x_a, x_w, y_a, y_w;
  logic [2:0]   c_a, c_w;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_in[i*9 +: 9]      = xs[i];
      y_in[i*9 +: 9]      = xs[i] + 9'd1;
      colour_in[i*3 +: 3] = 3'(i + 1);
    end
  end

  vga_plot_arbiter u_dut (
    .CLOCK_50(clk), .resetn(resetn), .req(req), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .gnt(gnt_a), .busy(busy_a), .x(x_a), .y(y_a), .colour(c_a), .plot(plot_a)
  );

  vga_plot_arbiter #(.MAX_BURST(8)) u_wd (
    .CLOCK_50(clk), .resetn(resetn), .req(req), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .gnt(gnt_w), .busy(busy_w), .x(x_w), .y(y_w), .colour(c_w), .plot(plot_w)
  );

  typedef struct {
    logic [N-1:0]      req;
    logic [N-1:0]      pl;
    logic [N-1:0][8:0] xs;
    logic [N-1:0]      g;
    logic              b;
    logic              p;
    logic [8:0]        ex;
    logic [8:0]        ey;
    logic [2:0]        ec;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] pl, input logic [N-1:0][8:0] lx,
                     input logic [N-1:0] g, input logic b, input logic p,
                     input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] ec);
    vec_t v;
    v.req = r; v.pl = pl; v.xs = lx; v.g = g; v.b = b; v.p = p;
    v.ex = ex; v.ey = ey; v.ec = ec;
    tv.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req = '0; plot_in = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [N-1:0][8:0] d, xv;
    int n;
    d = {9'd300, 9'd200, 9'd100, 9'd50};
    xs = d; req = '0; plot_in = '0; resetn = 1'b0;

    // Round-robin: all four request, each drops 3 cycles after its grant.
    for (int k = 0; k < N; k++) begin
      add(4'b1111, 4'b0000, d, 4'(1 << k), 1, 0, 0, 0, 0);
      add(4'b1111, 4'b0000, d, 4'(1 << k), 1, 0, 0, 0, 0);
      add(4'b1111, 4'b0000, d, 4'(1 << k), 1, 0, 0, 0, 0);
      add(4'b1111 & ~4'(1 << k), 4'b0000, d, 4'b0000, 0, 0, 0, 0, 0);
      add(4'b1111, 4'b0000, d, 4'b0000, 0, 0, 0, 0, 0);
    end
    add(4'b1111, 4'b0000, d, 4'b0001, 1, 0, 0, 0, 0);
    // Isolation: every lane strobes, only lane 0 may reach the outputs.
    for (int i = 0; i < 3; i++) begin
      xv = d; xv[0] = 9'(10 + i);
      add(4'b0001, 4'b1111, xv, 4'b0001, 1, 1, 9'(10 + i), 9'(11 + i), 3'd1);
    end
    xv = d; xv[0] = 9'd13;
    add(4'b0000, 4'b1111, xv, 4'b0000, 0, 1, 13, 14, 1);
    add(4'b0000, 4'b1111, xv, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b0000, 4'b1111, xv, 4'b0000, 0, 0, 13, 14, 1);
    // Late request: rr is 1 after lane 0, so lane 1 beats lane 3.
    add(4'b0001, 4'b0100, d, 4'b0001, 1, 0, 13, 14, 1);
    add(4'b0011, 4'b0100, d, 4'b0001, 1, 0, 13, 14, 1);
    add(4'b1011, 4'b0100, d, 4'b0001, 1, 0, 13, 14, 1);
    add(4'b1010, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b1010, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b1010, 4'b0100, d, 4'b0010, 1, 0, 13, 14, 1);
    add(4'b1000, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b1000, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b1000, 4'b0100, d, 4'b1000, 1, 0, 13, 14, 1);
    add(4'b0000, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    add(4'b0000, 4'b0100, d, 4'b0000, 0, 0, 13, 14, 1);
    // Single requester on lane 2, x = 5..14, one cycle late.
    add(4'b0100, 4'b0000, d, 4'b0100, 1, 0, 13, 14, 1);
    for (int i = 0; i < 10; i++) begin
      xv = d; xv[2] = 9'(5 + i);
      add(4'b0100, 4'b0100, xv, 4'b0100, 1, 1, 9'(5 + i), 9'(6 + i), 3'd3);
    end
    add(4'b0000, 4'b0000, d, 4'b0000, 0, 0, 14, 15, 3);
    add(4'b0000, 4'b0000, d, 4'b0000, 0, 0, 14, 15, 3);

    // Reset state.
    #3;
    chk("rst_dut", {gnt_a, busy_a, plot_a, x_a, y_a, c_a}, 32'd0);
    chk("rst_wd",  {gnt_w, busy_w, plot_w, x_w, y_w, c_w}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tv[i]) begin
      req = tv[i].req; plot_in = tv[i].pl; xs = tv[i].xs;
      tick();
      nvec++;
      if ({gnt_a, busy_a, plot_a, x_a, y_a, c_a} !==
          {tv[i].g, tv[i].b, tv[i].p, tv[i].ex, tv[i].ey, tv[i].ec}) begin
        nbad++;
        $display("FAIL vec%0d got gnt=%b busy=%b plot=%b x=%0d y=%0d c=%0d want gnt=%b busy=%b plot=%b x=%0d y=%0d c=%0d",
                 i, gnt_a, busy_a, plot_a, x_a, y_a, c_a,
                 tv[i].g, tv[i].b, tv[i].p, tv[i].ex, tv[i].ey, tv[i].ec);
      end
    end

    // Reset mid-burst with plot active: everything clears without a clock.
    xs = d; xs[2] = 9'd77;
    req = 4'b0100; plot_in = 4'b0100;
    tick();
    chk("mid_gnt", gnt_a, 4'b0100);
    tick();
    chk("mid_plot", {plot_a, x_a}, {1'b1, 9'd77});
    #2 resetn = 1'b0;
    #1;
    chk("mid_clear", {gnt_a, busy_a, plot_a, x_a, y_a, c_a}, 32'd0);
    req = 4'b0101; plot_in = '0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("post_rst_lane0", {gnt_a, busy_a}, {4'b0001, 1'b1});

    // Watchdog: lane 1 holds req forever, lane 3 arrives mid-burst.
    do_reset();
    req = 4'b0010;
    tick();
    chk("wd_first", gnt_w, 4'b0010);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) req = 4'b1010;
      tick();
      if (gnt_w[1]) n++;
      else break;
    end
    chk("wd_len", 32'(n), 32'd8);
    chk("wd_rel", {gnt_w, busy_w}, 5'b0);
    tick();
    chk("wd_gap", gnt_w, 4'b0000);
    tick();
    chk("wd_lane3", gnt_w, 4'b1000);
    tick();
    tick();
    chk("wd_lane3_hold", gnt_w, 4'b1000);
    req = 4'b0010;
    tick();
    chk("wd_lane3_rel", gnt_w, 4'b0000);
    tick();
    tick();
    chk("wd_lane1_again", gnt_w, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
